// File: rtl/multicycle_controller.sv
// Multi-cycle instruction sequencer: owns PC/IR and steps each instruction
// through FETCH, DECODE, EXEC, MEM and WB with a timed data-memory handshake.
module multicycle_controller #(
  parameter int unsigned     PC_W        = 32,
  parameter logic [PC_W-1:0] RESET_PC    = '0,
  parameter int unsigned     MEM_TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [31:0]     instr,
  input  logic [7:0]      ctrl,
  input  logic            alu_zero,
  input  logic            mem_ready,
  output logic [PC_W-1:0] pc,
  output logic [31:0]     ir,
  output logic [1:0]      alu_op,
  output logic            reg_write,
  output logic            mem_req,
  output logic            mem_we,
  output logic [2:0]      state,
  output logic            busy,
  output logic            halted,
  output logic            fault,
  output logic [31:0]     instr_count
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    HALT   = 3'd6
  } state_e;

  localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [31:0]     ir_q, ir_d;
  logic [7:0]      ctrl_q, ctrl_d;
  logic [7:0]      tmo_q, tmo_d;
  logic            fault_q, fault_d;
  logic [31:0]     cnt_q, cnt_d;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] pc_br;
  logic            retire;

  assign pc_inc = pc_q + PC_W'(1);
  assign pc_br  = pc_inc + PC_W'($signed(ir_q[15:0]));

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    ctrl_d  = ctrl_q;
    tmo_d   = tmo_q;
    fault_d = fault_q;
    case (state_q)
      IDLE: if (start) state_d = FETCH;
      FETCH: begin
        ir_d    = instr;
        state_d = DECODE;
      end
      DECODE: begin
        ctrl_d  = ctrl;
        state_d = ctrl[5] ? HALT : EXEC;
      end
      EXEC: begin
        if (ctrl_q[4]) begin
          pc_d    = PC_W'(ir_q[25:0]);
          state_d = FETCH;
        end else if (ctrl_q[3]) begin
          pc_d    = alu_zero ? pc_br : pc_inc;
          state_d = FETCH;
        end else if (ctrl_q[1] || ctrl_q[2]) begin
          tmo_d   = '0;
          state_d = MEM;
        end else if (ctrl_q[0]) begin
          state_d = WB;
        end else begin
          pc_d    = pc_inc;
          state_d = FETCH;
        end
      end
      MEM: begin
        if (mem_ready) begin
          tmo_d = '0;
          if (ctrl_q[1]) begin
            state_d = WB;
          end else begin
            pc_d    = pc_inc;
            state_d = FETCH;
          end
        end else if (tmo_q == TMO_LAST) begin
          fault_d = 1'b1;
          state_d = HALT;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      WB: begin
        pc_d    = pc_inc;
        state_d = FETCH;
      end
      HALT: state_d = HALT;
      default: begin
        fault_d = 1'b1;
        state_d = HALT;
      end
    endcase
  end

  // An instruction retires exactly when the sequencer loops back to FETCH.
  assign retire = (state_d == FETCH) &&
                  (state_q == EXEC || state_q == MEM || state_q == WB);
  assign cnt_d  = cnt_q + {31'd0, retire};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      ctrl_q  <= '0;
      tmo_q   <= '0;
      fault_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      ctrl_q  <= ctrl_d;
      tmo_q   <= tmo_d;
      fault_q <= fault_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pc          = pc_q;
  assign ir          = ir_q;
  assign state       = state_q;
  assign alu_op      = (state_q == EXEC || state_q == MEM) ? ctrl_q[7:6] : 2'b00;
  assign reg_write   = (state_q == WB);
  assign mem_req     = (state_q == MEM);
  assign mem_we      = (state_q == MEM) && ctrl_q[2];
  assign busy        = (state_q != IDLE) && (state_q != HALT);
  assign halted      = (state_q == HALT);
  assign fault       = fault_q;
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: a program-level reference model
// queues the expected per-instruction trace, a negedge monitor pops and compares.
module tb_multicycle_controller;

  localparam int TMO = 15;
  localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_EXEC = 3'd3,
                         S_MEM = 3'd4, S_HALT = 3'd6;
  localparam logic [5:0] OP_NOP = 6'd0, OP_ALU = 6'd1, OP_LD = 6'd2, OP_ST = 6'd3,
                         OP_RMW = 6'd4, OP_BR = 6'd5, OP_JMP = 6'd6, OP_HLT = 6'd7,
                         OP_REG = 6'd8;

  logic        clk, rst_n, start, alu_zero, mem_ready;
  logic [31:0] instr, ir, instr_count, pc;
  logic [7:0]  ctrl;
  logic [1:0]  alu_op;
  logic        reg_write, mem_req, mem_we, busy, halted, fault;
  logic [2:0]  state;

  logic [31:0] imem [64];
  int mem_delay = 0;
  int mem_cyc = 0;
  int n_checks = 0;
  int n_pass = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] cnt;
    int          lat;
    int          nrw;
    int          nmem;
    logic        we;
    logic [1:0]  alu;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        cur;
  logic [31:0] exp_pc, exp_cnt;
  logic        exp_fault;
  bit          mon_en = 0;
  bit          in_instr = 0;
  int          lat, nrw, nmem, stray;
  logic        we_seen;
  logic [1:0]  alu_seen;

  multicycle_controller #(
    .PC_W       (32),
    .RESET_PC   (32'd0),
    .MEM_TIMEOUT(TMO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .instr      (instr),
    .ctrl       (ctrl),
    .alu_zero   (alu_zero),
    .mem_ready  (mem_ready),
    .pc         (pc),
    .ir         (ir),
    .alu_op     (alu_op),
    .reg_write  (reg_write),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .state      (state),
    .busy       (busy),
    .halted     (halted),
    .fault      (fault),
    .instr_count(instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] ctrl_of(input logic [5:0] op);
    case (op)
      OP_ALU:  return 8'h41;
      OP_LD:   return 8'h83;
      OP_ST:   return 8'h04;
      OP_RMW:  return 8'h06;
      OP_BR:   return 8'h48;
      OP_JMP:  return 8'h10;
      OP_HLT:  return 8'h20;
      OP_REG:  return 8'h01;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [25:0] arg);
    return {op, arg};
  endfunction

  assign instr     = imem[pc[5:0]];
  assign ctrl      = ctrl_of(ir[31:26]);
  assign mem_ready = (mem_cyc == mem_delay);

  always @(posedge clk) mem_cyc <= mem_req ? mem_cyc + 1 : 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 64; i++) imem[i] = mk(OP_HLT, 26'd0);
  endtask

  task automatic predict(input logic az, input int dly);
    logic [31:0] p, c, w;
    logic [7:0]  k;
    exp_t        e;
    bit          done;
    p = 32'd0; c = 32'd0; done = 0; exp_fault = 1'b0;
    exp_q.delete();
    for (int s = 0; s < 64 && !done; s++) begin
      w = imem[p[5:0]];
      k = ctrl_of(w[31:26]);
      e.pc = p; e.cnt = c; e.lat = 3; e.nrw = 0; e.nmem = 0; e.we = 1'b0;
      e.alu = k[5] ? 2'b00 : k[7:6];
      if (k[5]) begin
        e.lat = 2; done = 1;
      end else if (k[4]) begin
        p = {6'd0, w[25:0]}; c++;
      end else if (k[3]) begin
        p = p + 32'd1 + (az ? {{16{w[15]}}, w[15:0]} : 32'd0); c++;
      end else if (k[1] || k[2]) begin
        e.we = k[2];
        if (dly >= TMO) begin
          e.lat = 3 + TMO; e.nmem = TMO; exp_fault = 1'b1; done = 1;
        end else begin
          e.nmem = dly + 1; e.nrw = int'(k[1]); e.lat = 4 + dly + int'(k[1]);
          p++; c++;
        end
      end else if (k[0]) begin
        e.lat = 4; e.nrw = 1; p++; c++;
      end else begin
        p++; c++;
      end
      exp_q.push_back(e);
    end
    exp_pc = p; exp_cnt = c;
  endtask

  task automatic finish_instr();
    chk("latency", lat, cur.lat);
    chk("reg_write_cycles", nrw, cur.nrw);
    chk("mem_req_cycles", nmem, cur.nmem);
    chk("mem_we", we_seen, cur.we);
    chk("alu_op_exec", alu_seen, cur.alu);
    chk("stray_outputs", stray, 0);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (state == S_FETCH) begin
          if (in_instr) finish_instr();
          chk("fetch_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            cur = exp_q.pop_front();
            chk("fetch_pc", pc, cur.pc);
            chk("fetch_count", instr_count, cur.cnt);
          end
          in_instr = 1; lat = 0; nrw = 0; nmem = 0; stray = 0;
          we_seen = 1'b0; alu_seen = 2'b00;
        end else if (state == S_HALT && in_instr) begin
          finish_instr();
          in_instr = 0;
        end
        if (in_instr) begin
          lat++;
          nrw  += int'(reg_write);
          nmem += int'(mem_req);
          if (mem_req && mem_we) we_seen = 1'b1;
          if (state == S_EXEC) alu_seen = alu_op;
          if ((state == S_EXEC || state == S_MEM) ? (alu_op != cur.alu) : (alu_op != 2'b00))
            stray++;
          if (mem_we && !mem_req) stray++;
        end
      end
    end
  end

  task automatic run(input string name, input logic az, input int dly);
    rst_n = 1'b0; start = 1'b0; alu_zero = az; mem_delay = dly; in_instr = 0;
    predict(az, dly);
    repeat (2) @(negedge clk);
    chk({name, ":rst_state"}, state, S_IDLE);
    chk({name, ":rst_pc"}, pc, 32'd0);
    chk({name, ":rst_ir"}, ir, 32'd0);
    chk({name, ":rst_count"}, instr_count, 32'd0);
    chk({name, ":rst_outs"}, {alu_op, reg_write, mem_req, mem_we, busy, halted, fault}, 0);
    rst_n = 1'b1; mon_en = 1;
    @(negedge clk);
    chk({name, ":idle_hold"}, state, S_IDLE);
    start = 1'b1;
    for (int i = 0; i < 500 && !halted; i++) @(negedge clk);
    chk({name, ":reach_halt"}, halted, 1'b1);
    @(negedge clk);
    chk({name, ":final_pc"}, pc, exp_pc);
    chk({name, ":final_count"}, instr_count, exp_cnt);
    chk({name, ":final_fault"}, fault, exp_fault);
    chk({name, ":final_busy"}, busy, 1'b0);
    chk({name, ":trace_drained"}, exp_q.size(), 0);
    for (int i = 0; i < 6; i++) begin
      start = i[0];
      @(negedge clk);
    end
    chk({name, ":halt_sticky"}, state, S_HALT);
    chk({name, ":halt_pc"}, pc, exp_pc);
    chk({name, ":halt_count"}, instr_count, exp_cnt);
    mon_en = 0; start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b1; start = 1'b0; alu_zero = 1'b0;
    #1;

    clear_prog();
    for (int i = 0; i < 3; i++) imem[i] = mk(OP_NOP, 26'd0);
    run("nops", 1'b0, 0);

    clear_prog();
    imem[0] = mk(OP_ALU, 26'd0);
    run("alu", 1'b0, 0);

    clear_prog();
    imem[0] = mk(OP_JMP, 26'd5);
    imem[5] = mk(OP_BR, {10'd0, 16'hFFFC});
    run("br_taken", 1'b1, 0);
    run("br_not", 1'b0, 0);

    clear_prog();
    imem[0] = mk(OP_LD, 26'd0);
    imem[1] = mk(OP_ST, 26'd0);
    imem[2] = mk(OP_RMW, 26'd0);
    imem[3] = mk(OP_REG, 26'd0);
    run("mem", 1'b0, 3);

    clear_prog();
    imem[0] = mk(OP_NOP, 26'd0);
    imem[1] = mk(OP_LD, 26'd0);
    run("timeout", 1'b0, 1000);

    clear_prog();
    for (int i = 0; i < 4; i++) imem[i] = mk(OP_NOP, 26'd0);
    run("halt4", 1'b0, 0);

    // Asynchronous reset while a load waits in MEM.
    clear_prog();
    imem[0] = mk(OP_NOP, 26'd0);
    imem[1] = mk(OP_LD, 26'd0);
    rst_n = 1'b0; start = 1'b0; mem_delay = 1000;
    repeat (2) @(negedge clk);
    rst_n = 1'b1; start = 1'b1;
    for (int i = 0; i < 20 && !mem_req; i++) @(negedge clk);
    chk("midmem_reached", mem_req, 1'b1);
    @(negedge clk);
    chk("midmem_pc", pc, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_mem_req", mem_req, 1'b0);
    chk("arst_state", state, S_IDLE);
    chk("arst_pc", pc, 32'd0);
    chk("arst_count", instr_count, 32'd0);
    chk("arst_ir", ir, 32'd0);
    chk("arst_outs", {alu_op, reg_write, mem_we, busy, halted, fault}, 0);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("arst_idle_after", state, S_IDLE);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
